// File: rtl/stack_seq.sv
// Stack primitive sequencer: expands LIT/DROP/DUP/SWAP/OVER/ROT into timed PUSH/POP bus ops.
// Define FORTHSUPER_STACK_SEQ_ROT_EN to build ROT (opcode 6); otherwise opcode 6 is rejected.
module stack_seq #(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int DW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [DSZ-1:0] cmd_val,
    output logic [1:0]     ss_op,
    output logic [DSZ-1:0] ss_vi,
    output logic           ss_en,
    input  logic [DSZ-1:0] ss_s,
    output logic           done,
    output logic           err,
    output logic [DW-1:0]  depth
);
    localparam logic [1:0] SS_READ = 2'd0, SS_PUSH = 2'd1, SS_POP = 2'd2;
    localparam logic [2:0] OP_NOP = 3'd0, OP_LIT = 3'd1, OP_DROP = 3'd2, OP_DUP = 3'd3,
                           OP_SWAP = 3'd4, OP_OVER = 3'd5, OP_ROT = 3'd6;
    localparam logic [1:0] SRC_VAL = 2'd0, SRC_T0 = 2'd1, SRC_T1 = 2'd2, SRC_T2 = 2'd3;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [DSZ-1:0] val_q, val_d, t0_q, t0_d, t1_q, t1_d;
    logic [2:0]     step_q, step_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic           rej_q, rej_d;
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
    logic [DSZ-1:0] t2_q, t2_d;
`endif

    logic           step_push;
    logic [1:0]     step_src;
    logic [2:0]     n_steps;
    logic [DSZ-1:0] src_val;
    logic [DW-1:0]  need;
    logic           grows, op_ok, legal;

    // Step table for the latched primitive: direction and push source of step_q.
    always_comb begin
        step_push = 1'b0;
        step_src  = SRC_VAL;
        n_steps   = 3'd1;
        case (op_q)
            OP_LIT:  step_push = 1'b1;
            OP_DUP:  begin step_push = 1'b1; step_src = SRC_T0; end
            OP_SWAP: begin
                n_steps   = 3'd4;
                step_push = (step_q >= 3'd2);
                step_src  = (step_q == 3'd3) ? SRC_T1 : SRC_T0;
            end
            OP_OVER: begin
                n_steps   = 3'd3;
                step_push = (step_q >= 3'd1);
                step_src  = (step_q == 3'd2) ? SRC_T1 : SRC_T0;
            end
            OP_ROT: begin
                n_steps   = 3'd6;
                step_push = (step_q >= 3'd3);
                step_src  = (step_q == 3'd3) ? SRC_T1 : (step_q == 3'd4) ? SRC_T0 : SRC_T2;
            end
            default: ;
        endcase
    end

    always_comb begin
        src_val = val_q;
        case (step_src)
            SRC_T0:  src_val = t0_q;
            SRC_T1:  src_val = t1_q;
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
            SRC_T2:  src_val = t2_q;
`endif
            default: src_val = val_q;
        endcase
    end

    always_comb begin
        need  = '0;
        grows = 1'b0;
        op_ok = 1'b1;
        case (cmd_op)
            OP_LIT:  grows = 1'b1;
            OP_DROP: need = DW'(1);
            OP_DUP:  begin need = DW'(1); grows = 1'b1; end
            OP_SWAP: need = DW'(2);
            OP_OVER: begin need = DW'(2); grows = 1'b1; end
            OP_ROT:  begin need = DW'(3); op_ok = ROT_EN; end
            OP_NOP:  ;
            default: op_ok = 1'b0;
        endcase
        legal = op_ok && (depth_q >= need) && (!grows || depth_q < DEPTH_MAX);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        val_d     = val_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
        t2_d      = t2_q;
`endif
        step_d    = step_q;
        depth_d   = depth_q;
        rej_d     = rej_q;
        cmd_ready = 1'b0;
        ss_op     = SS_READ;
        ss_vi     = '0;
        ss_en     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    val_d   = cmd_val;
                    t0_d    = ss_s;
                    step_d  = '0;
                    rej_d   = !legal;
                    state_d = (!legal || cmd_op == OP_NOP) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                ss_en   = 1'b1;
                ss_op   = step_push ? SS_PUSH : SS_POP;
                ss_vi   = step_push ? src_val : '0;
                depth_d = step_push ? depth_q + 1'b1 : depth_q - 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // ss_s has settled to the post-op TOS by the end of this cycle.
                if (step_q == 3'd0 && (op_q == OP_SWAP || op_q == OP_OVER || op_q == OP_ROT))
                    t1_d = ss_s;
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
                if (step_q == 3'd1 && op_q == OP_ROT)
                    t2_d = ss_s;
`endif
                if (step_q == n_steps - 3'd1) begin
                    state_d = DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = ISSUE;
                end
            end
            DONE: begin
                done    = !rej_q;
                err     = rej_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            val_q   <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
            t2_q    <= '0;
`endif
            step_q  <= '0;
            depth_q <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            val_q   <= val_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
            t2_q    <= t2_d;
`endif
            step_q  <= step_d;
            depth_q <= depth_d;
            rej_q   <= rej_d;
        end
    end

    assign depth = depth_q;

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: directed cases plus randomized primitives vs a list-level stack model.
module tb_stack_seq;
    localparam int DEPTH = 4;
    localparam int DSZ   = 32;
    localparam int DW    = $clog2(DEPTH) + 1;
    localparam logic [1:0] SS_READ = 2'd0, SS_PUSH = 2'd1, SS_POP = 2'd2;
`ifdef FORTHSUPER_STACK_SEQ_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic           clk, rst, cmd_valid, cmd_ready, ss_en, done, err;
    logic [2:0]     cmd_op;
    logic [DSZ-1:0] cmd_val, ss_vi, ss_s;
    logic [1:0]     ss_op;
    logic [DW-1:0]  depth;

    int n_chk = 0, n_pass = 0;

    typedef struct {
        int dcyc; int ecyc; int encnt; int first_en; int rdylow; bit rdy_after;
    } obs_t;

    stack_seq #(.DEPTH(DEPTH), .DSZ(DSZ), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_val(cmd_val), .ss_op(ss_op), .ss_vi(ss_vi),
        .ss_en(ss_en), .ss_s(ss_s), .done(done), .err(err), .depth(depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached data stack: TOS register updated on each enabled op, shares rst.
    logic [DSZ-1:0] stk[$];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk.delete();
            ss_s <= '0;
        end else if (ss_en) begin
            if (ss_op == SS_PUSH) stk.push_back(ss_vi);
            else if (ss_op == SS_POP && stk.size() > 0) void'(stk.pop_back());
            ss_s <= (stk.size() > 0) ? stk[$] : '0;
        end
    end

    // Reference: Forth semantics on a list, plus the primitive's step count.
    logic [DSZ-1:0] rq[$];
    task automatic ref_step(input logic [2:0] op, input logic [DSZ-1:0] v,
                            output bit e, output int n);
        logic [DSZ-1:0] x, y;
        int sz;
        sz = rq.size();
        e = 1'b0;
        n = 0;
        case (op)
            3'd0: n = 0;
            3'd1: if (sz < DEPTH) begin rq.push_back(v); n = 1; end else e = 1'b1;
            3'd2: if (sz >= 1) begin void'(rq.pop_back()); n = 1; end else e = 1'b1;
            3'd3: if (sz >= 1 && sz < DEPTH) begin x = rq[sz-1]; rq.push_back(x); n = 1; end
                  else e = 1'b1;
            3'd4: if (sz >= 2) begin
                      x = rq[sz-1]; y = rq[sz-2]; rq[sz-1] = y; rq[sz-2] = x; n = 4;
                  end else e = 1'b1;
            3'd5: if (sz >= 2 && sz < DEPTH) begin x = rq[sz-2]; rq.push_back(x); n = 3; end
                  else e = 1'b1;
            3'd6: if (ROT_EN && sz >= 3) begin
                      x = rq[sz-3]; rq.delete(sz-3); rq.push_back(x); n = 6;
                  end else e = 1'b1;
            default: e = 1'b1;
        endcase
    endtask

    // Drives one command from cycle 0 and observes until done/err; returns at cycle end+1.
    task automatic run_cmd(input logic [2:0] op, input logic [DSZ-1:0] v, output obs_t o);
        o.dcyc = -1; o.ecyc = -1; o.encnt = 0; o.first_en = -1; o.rdylow = 0; o.rdy_after = 1'b0;
        cmd_op = op; cmd_val = v; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_val = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ss_en) begin o.encnt++; if (o.first_en < 0) o.first_en = c; end
            if (!cmd_ready) o.rdylow++;
            if (done) o.dcyc = c;
            if (err) o.ecyc = c;
            @(posedge clk); #1;
            if (o.dcyc > 0 || o.ecyc > 0) begin o.rdy_after = cmd_ready; break; end
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; cmd_op = '0; cmd_val = '0;
        rst = 1'b0;
        rq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_val = '0;
        #3;
        n_chk++;
        if ({cmd_ready, ss_op, ss_vi, ss_en, done, err, depth} !==
            {1'b1, SS_READ, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0})
            $display("FAIL reset_state got rdy=%b op=%0d vi=%h en=%b done=%b err=%b depth=%0d",
                     cmd_ready, ss_op, ss_vi, ss_en, done, err, depth);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_lit();
        obs_t o; bit e; int n;
        do_reset();
        ref_step(3'd1, 32'h11, e, n);
        run_cmd(3'd1, 32'h11, o);
        n_chk++; if (o.dcyc !== 3 || o.first_en !== 1 || o.encnt !== 1)
            $display("FAIL lit1_timing got done=%0d en_first=%0d en_cnt=%0d exp 3/1/1", o.dcyc, o.first_en, o.encnt);
        else n_pass++;
        ref_step(3'd1, 32'h22, e, n);
        run_cmd(3'd1, 32'h22, o);
        n_chk++; if (o.dcyc !== 3 || o.first_en !== 1 || o.encnt !== 1 || o.rdy_after !== 1'b1)
            $display("FAIL lit2_timing got done=%0d en_first=%0d en_cnt=%0d rdy=%b", o.dcyc, o.first_en, o.encnt, o.rdy_after);
        else n_pass++;
        n_chk++; if (ss_s !== 32'h22 || depth !== 3'd2)
            $display("FAIL lit_result got tos=%h depth=%0d exp 22/2", ss_s, depth);
        else n_pass++;
    endtask

    task automatic test_swap();
        obs_t o;
        do_reset();
        run_cmd(3'd1, 32'h11, o);
        run_cmd(3'd1, 32'h22, o);
        run_cmd(3'd4, 32'h0, o);
        n_chk++; if (o.dcyc !== 9 || o.encnt !== 4 || o.rdylow !== 9)
            $display("FAIL swap_timing got done=%0d en_cnt=%0d rdy_low=%0d exp 9/4/9", o.dcyc, o.encnt, o.rdylow);
        else n_pass++;
        n_chk++; if (ss_s !== 32'h11 || depth !== 3'd2)
            $display("FAIL swap_result got tos=%h depth=%0d exp 11/2", ss_s, depth);
        else n_pass++;
        run_cmd(3'd2, 32'h0, o);
        n_chk++; if (ss_s !== 32'h22 || depth !== 3'd1 || o.dcyc !== 3)
            $display("FAIL swap_drop got tos=%h depth=%0d done=%0d exp 22/1/3", ss_s, depth, o.dcyc);
        else n_pass++;
    endtask

    task automatic test_over();
        obs_t o;
        do_reset();
        run_cmd(3'd1, 32'h11, o);
        run_cmd(3'd1, 32'h22, o);
        run_cmd(3'd5, 32'h0, o);
        n_chk++; if (o.dcyc !== 7 || o.encnt !== 3 || ss_s !== 32'h11 || depth !== 3'd3)
            $display("FAIL over got done=%0d en_cnt=%0d tos=%h depth=%0d exp 7/3/11/3", o.dcyc, o.encnt, ss_s, depth);
        else n_pass++;
        run_cmd(3'd2, 32'h0, o);
        n_chk++; if (ss_s !== 32'h22) $display("FAIL over_drop1 got tos=%h exp 22", ss_s); else n_pass++;
        run_cmd(3'd2, 32'h0, o);
        n_chk++; if (ss_s !== 32'h11) $display("FAIL over_drop2 got tos=%h exp 11", ss_s); else n_pass++;
    endtask

    task automatic test_rot();
        obs_t o; bit e; int n;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            ref_step(3'd1, 32'(i * 'h11), e, n);
            run_cmd(3'd1, 32'(i * 'h11), o);
        end
        ref_step(3'd6, 32'h0, e, n);
        run_cmd(3'd6, 32'h0, o);
        n_chk++; if (o.dcyc !== (ROT_EN ? 13 : -1) || o.ecyc !== (ROT_EN ? -1 : 1) ||
                     o.encnt !== (ROT_EN ? 6 : 0) || depth !== 3'd3)
            $display("FAIL rot got done=%0d err=%0d en_cnt=%0d depth=%0d", o.dcyc, o.ecyc, o.encnt, depth);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (ss_s !== rq[rq.size()-1])
                $display("FAIL rot_order k=%0d got tos=%h exp %h", k, ss_s, rq[rq.size()-1]);
            else n_pass++;
            ref_step(3'd2, 32'h0, e, n);
            run_cmd(3'd2, 32'h0, o);
        end
    endtask

    task automatic test_errors();
        obs_t o;
        do_reset();
        run_cmd(3'd2, 32'h0, o);
        n_chk++; if (o.ecyc !== 1 || o.dcyc !== -1 || o.encnt !== 0 || depth !== 3'd0 || o.rdy_after !== 1'b1)
            $display("FAIL err_drop_empty got err=%0d done=%0d en_cnt=%0d depth=%0d", o.ecyc, o.dcyc, o.encnt, depth);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) run_cmd(3'd1, 32'(i + 1), o);
        run_cmd(3'd1, 32'hdead, o);
        n_chk++; if (o.ecyc !== 1 || o.encnt !== 0 || depth !== 3'd4 || stk.size() !== 4)
            $display("FAIL err_lit_full got err=%0d en_cnt=%0d depth=%0d", o.ecyc, o.encnt, depth);
        else n_pass++;
        run_cmd(3'd7, 32'h0, o);
        n_chk++; if (o.ecyc !== 1 || o.encnt !== 0 || depth !== 3'd4 || ss_s !== 32'd4)
            $display("FAIL err_op7 got err=%0d en_cnt=%0d depth=%0d tos=%h", o.ecyc, o.encnt, depth, ss_s);
        else n_pass++;
        run_cmd(3'd0, 32'h0, o);
        n_chk++; if (o.dcyc !== 1 || o.ecyc !== -1 || o.encnt !== 0 || o.rdy_after !== 1'b1)
            $display("FAIL nop got done=%0d err=%0d en_cnt=%0d", o.dcyc, o.ecyc, o.encnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic en_before;
        do_reset();
        run_cmd(3'd1, 32'h11, o);
        run_cmd(3'd1, 32'h22, o);
        cmd_op = 3'd4; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 en_before = ss_en;
        rst = 1'b0;
        #1;
        n_chk++;
        if (en_before !== 1'b1 ||
            {cmd_ready, ss_op, ss_vi, ss_en, done, err, depth} !==
            {1'b1, SS_READ, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0})
            $display("FAIL reset_mid got en_before=%b rdy=%b op=%0d vi=%h en=%b depth=%0d",
                     en_before, cmd_ready, ss_op, ss_vi, ss_en, depth);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_mid_ready got %b exp 1", cmd_ready); else n_pass++;
        run_cmd(3'd1, 32'h55, o);
        n_chk++; if (o.dcyc !== 3 || ss_s !== 32'h55 || depth !== 3'd1)
            $display("FAIL reset_mid_lit got done=%0d tos=%h depth=%0d exp 3/55/1", o.dcyc, ss_s, depth);
        else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        obs_t o; bit e; int n; bit same;
        logic [2:0] op; logic [DSZ-1:0] v;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            v  = $urandom;
            ref_step(op, v, e, n);
            run_cmd(op, v, o);
            n_chk++;
            if (o.ecyc !== (e ? 1 : -1) || o.dcyc !== (e ? -1 : 2 * n + 1) || o.encnt !== n ||
                o.rdylow !== (e ? 1 : 2 * n + 1) || o.rdy_after !== 1'b1)
                $display("FAIL rand_timing i=%0d op=%0d got err=%0d done=%0d en=%0d rdylow=%0d exp e=%0b n=%0d",
                         i, op, o.ecyc, o.dcyc, o.encnt, o.rdylow, e, n);
            else n_pass++;
            same = (stk.size() == rq.size());
            for (int k = 0; k < rq.size() && same; k++) same = (stk[k] === rq[k]);
            n_chk++;
            if (!same || int'(depth) !== rq.size() ||
                ss_s !== ((rq.size() > 0) ? rq[rq.size()-1] : 32'h0))
                $display("FAIL rand_state i=%0d op=%0d got depth=%0d tos=%h exp depth=%0d", i, op, depth, ss_s, rq.size());
            else n_pass++;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_val = '0;
        test_reset();
        test_lit();
        test_swap();
        test_over();
        test_rot();
        test_errors();
        test_reset_mid();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
# stack_seq

Stack primitive sequencer: the initiator end of the stack bus. It accepts one Forth stack-manipulation primitive per command (LIT, DROP, DUP, SWAP, OVER, ROT) over a valid/ready handshake. It expands the primitive into a timed series of PUSH/POP operations on the pseudo dual-port data stack, whose TOS register is visible to it as `ss_s`. It sits between the instruction decoder and the stack, tracks stack depth, and rejects primitives that would underflow or overflow.

## Interface
Parameters:
- DEPTH, 64, stack entries; must match the attached stack
- DSZ, 32, data width
- DW, $clog2(DEPTH)+1, depth counter width (0..DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  primitive: 0 NOP, 1 LIT, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 ROT, 7 reserved
- cmd_val  in  DSZ  literal for LIT
- ss_op  out  2  stack op (PUSH/POP/READ encoding of stack_ops)
- ss_vi  out  DSZ  value pushed
- ss_en  out  1  stack enable, high only in issue cycles
- ss_s  in  DSZ  current stack TOS
- done  out  1  one-cycle pulse, primitive completed
- err  out  1  one-cycle pulse, primitive rejected
- depth  out  DW  current entry count

## Operation
- Reset values: cmd_ready=1, ss_op=READ, ss_vi=0, ss_en=0, done=0, err=0, depth=0, FSM=IDLE.
- cmd_op and cmd_val are latched at accept. The TOS is captured into t0 at accept.
- Legality is checked at accept.
  - Minimum depth: DROP/DUP 1, SWAP/OVER 2, ROT 3.
  - Push headroom: depth+1<=DEPTH for LIT/DUP/OVER.
  - Opcode 7 is illegal.
- An illegal command pulses err in the cycle after accept. It issues no bus op and leaves depth unchanged, then returns to IDLE.
- FSM states are IDLE, ISSUE, WAIT and DONE.
  - ISSUE drives ss_en=1 with op/vi for one cycle.
  - WAIT drives ss_en=0, ss_op=READ for exactly one cycle, which lets NOS settle. Captures happen at the end of WAIT.
  - After the last WAIT the FSM goes to DONE, which pulses done and returns to IDLE.
- Step lists (a b c, c on top; tN = captured values):
  - LIT: PUSH cmd_val.
  - DROP: POP.
  - DUP: PUSH t0.
  - SWAP: POP, capture t1; POP; PUSH t0; PUSH t1.
  - OVER: POP, capture t1; PUSH t0; PUSH t1.
  - ROT: POP, capture t1; POP, capture t2; POP; PUSH t1; PUSH t0; PUSH t2.
- depth changes by ±1 on every ISSUE edge (PUSH/POP). Net effect per primitive: LIT/DUP/OVER +1, DROP −1, others 0.
- NOP: no bus ops; done pulses the cycle after accept.
- Reset mid-primitive returns immediately to the reset state. The stack must be reset by the same rst, because a partial sequence leaves it inconsistent.

## Timing
- An accept in cycle 0 starts step k's ISSUE in cycle 2k+1 and its WAIT in cycle 2k+2.
- An N-step primitive pulses done in cycle 2N+1. cmd_ready is 0 from cycle 1 through cycle 2N+1 and returns to 1 in cycle 2N+2.
- Step counts and done cycle: LIT/DROP/DUP N=1, done cycle 3. SWAP N=4, cycle 9. OVER N=3, cycle 7. ROT N=6, cycle 13.
- err and NOP done both occur in cycle 1, with cmd_ready high again in cycle 2.
- Back-to-back commands are allowed: a new accept may occur in the first cycle cmd_ready is high.
- ss_s is sampled only at accept and at the end of WAIT, never in ISSUE.

## Configuration
- FORTHSUPER_STACK_SEQ_ROT_EN defined: ROT (opcode 6) is implemented as above, and the t2 register and 6-step sequence are built.
- Not defined: opcode 6 is illegal and pulses err with no bus activity, and t2 is not synthesized.

## Test plan
- Setup: DEPTH=4, macro defined.
- Reset, LIT 0x11, LIT 0x22 -> each done in cycle 3; ss_s=0x22, depth=2; ss_en high exactly in cycle 1 of each command.
- On stack 11 22: SWAP -> done in cycle 9, ss_s=0x11, depth=2; then DROP -> ss_s=0x22, depth=1.
- On stack 11 22: OVER -> done in cycle 7, ss_s=0x11, depth=3; then DROP, DROP -> ss_s 0x22 then 0x11.
- On stack 11 22 33: ROT -> done in cycle 13, TOS order 0x11, 0x33, 0x22 via successive DROPs. With the macro undefined, ROT -> err in cycle 1, depth=3 unchanged.
- Error cases, each -> err in cycle 1, no ss_en, depth unchanged:
  - DROP on empty stack.
  - LIT at depth=4.
  - Opcode 7.
- Assert rst in cycle 3 of a SWAP -> all outputs at their reset values immediately, depth=0; cmd_ready=1 after release; the next LIT executes normally.
